// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared constants and FSM state type for the serial CRC checker
package crc_pkg;

   localparam logic [4:0] GPE    = 5'b10111;
   localparam int         CW_LEN = 7;
   localparam int         DATA_W = 3;
   localparam int         CRC_W  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

endpackage

// File: rtl/crc_serial_div.sv
// rtl/crc_serial_div.sv - bit-serial polynomial divider holding the 4-bit remainder
module crc_serial_div #(
   parameter logic [3:0] FB_MASK = 4'b0111
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_load,
   input  logic       i_step,
   input  logic       i_bit,
   output logic [3:0] o_rem_next
);

   logic [3:0] rem;

   // Remainder after absorbing i_bit; the top samples this on the last bit so the
   // pass/fail result can be registered on the same edge as that bit.
   assign o_rem_next = {rem[2:0], i_bit} ^ (rem[3] ? FB_MASK : 4'b0000);

   // Load starts a new division with the first bit, step divides one more bit in.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rem <= 4'b0000;
      end else if (i_load) begin
         rem <= {3'b000, i_bit};
      end else if (i_step) begin
         rem <= o_rem_next;
      end
   end

endmodule

// File: rtl/crc_check_serial.sv
// rtl/crc_check_serial.sv - serial 7-bit codeword CRC checker with error counter
module crc_check_serial #(
   parameter logic [4:0] GPE    = 5'b10111,
   parameter int         CW_LEN = 7
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_bit_valid,
   input  logic       i_bit,
   input  logic       i_sync,
   output logic [2:0] o_data,
   output logic       o_data_valid,
   output logic       o_crc_err,
   output logic [7:0] o_err_cnt,
   output logic       o_frame_abort
);

   import crc_pkg::*;

   localparam logic [2:0] LAST_CNT = 3'(CW_LEN - 1);

   state_t     state;
   state_t     state_next;
   logic [2:0] count;
   logic [6:0] shreg;
   logic       div_load;
   logic       div_step;
   logic       frame_done;
   logic       frame_abort;
   logic [3:0] rem_next;
   logic       rem_nonzero;

   crc_serial_div #(
      .FB_MASK (GPE[3:0])
   ) u_div (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_load     (div_load),
      .i_step     (div_step),
      .i_bit      (i_bit),
      .o_rem_next (rem_next)
   );

   assign rem_nonzero = (rem_next != 4'b0000);

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and per-bit control: a sync bit always (re)starts a frame; the
   // seventh plain bit completes it and drops back to IDLE.
   always_comb begin
      state_next  = state;
      div_load    = 1'b0;
      div_step    = 1'b0;
      frame_done  = 1'b0;
      frame_abort = 1'b0;
      case (state)
         IDLE: begin
            if (i_bit_valid && i_sync) begin
               div_load   = 1'b1;
               state_next = RECV;
            end
         end
         RECV: begin
            if (i_bit_valid) begin
               if (i_sync) begin
                  div_load    = 1'b1;
                  frame_abort = 1'b1;
               end else begin
                  div_step = 1'b1;
                  if (count == LAST_CNT) begin
                     frame_done = 1'b1;
                     state_next = IDLE;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Bit counter and capture shift register, tracking the divider.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         count <= 3'd0;
         shreg <= 7'd0;
      end else if (div_load) begin
         count <= 3'd1;
         shreg <= {6'd0, i_bit};
      end else if (div_step) begin
         count <= frame_done ? 3'd0 : count + 3'd1;
         shreg <= {shreg[5:0], i_bit};
      end
   end

   // Registered results; the data bits are the three oldest captured bits, which
   // sit at shreg[5:3] while the seventh bit is still on the input.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_data        <= 3'd0;
         o_data_valid  <= 1'b0;
         o_crc_err     <= 1'b0;
         o_err_cnt     <= 8'd0;
         o_frame_abort <= 1'b0;
      end else begin
         o_data_valid  <= frame_done;
         o_frame_abort <= frame_abort;
         if (frame_done) begin
            o_data    <= shreg[5:3];
            o_crc_err <= rem_nonzero;
            if (rem_nonzero && (o_err_cnt != 8'hFF)) begin
               o_err_cnt <= o_err_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: doc/crc_check_serial.md
# crc_check_serial

Serial CRC checker for the 3-bit-data / 4-bit-CRC link (generator 5'b10111, x^4+x^2+x+1). It sits directly downstream of the CRC encoder and its serializer. It accepts the 7-bit codeword one bit per valid cycle, MSB first, and divides it by the generator on the fly. After the last bit it presents the recovered 3-bit data with a pass/fail flag, and it keeps a saturating error count.

## Interface
Parameters:
- GPE, 5'b10111, generator polynomial; the low 4 bits 4'b0111 form the feedback mask
- CW_LEN, 7, codeword length in bits (3 data + 4 CRC)

Ports:
- i_clk  input  1  clock
- i_reset_n  input  1  reset, asynchronous, active-low
- i_bit_valid  input  1  i_bit is valid this cycle
- i_bit  input  1  serial codeword bit, MSB first (d2 d1 d0 c3 c2 c1 c0)
- i_sync  input  1  marks the first bit of a codeword; qualified by i_bit_valid
- o_data  output  3  recovered data bits d2..d0; holds its value between frames
- o_data_valid  output  1  one-cycle pulse per completed codeword
- o_crc_err  output  1  remainder non-zero for the frame; valid with o_data_valid, holds its value afterwards
- o_err_cnt  output  8  number of failed frames, saturates at 255
- o_frame_abort  output  1  one-cycle pulse when a frame is restarted by a premature i_sync

## Operation
- States:
  - IDLE: waiting for a sync bit.
  - RECV: codeword in progress; 3-bit counter holds the number of bits accepted.
- Remainder update per accepted bit b, with 4-bit r and fb = r[3]: r_next = {r[2:0], b} ^ (fb ? GPE[3:0] : 4'b0).
  - A 7-bit shift register captures the bits alongside.
- IDLE:
  - i_bit_valid and i_sync: r = {3'b0, i_bit}, shift register = {6'b0, i_bit}, count = 1, go to RECV.
  - Any other input: ignore it.
- RECV with i_bit_valid and not i_sync: perform the update and increment the count.
  - If this is the 7th bit, register the outputs, clear the count and return to IDLE in the same edge.
- RECV with i_bit_valid and i_sync: abort the current frame.
  - Pulse o_frame_abort.
  - Restart with this bit as the first bit (count = 1), staying in RECV.
  - Emit no o_data_valid for the aborted frame.
- i_bit_valid low: no state change. Gaps of any length are allowed mid-frame.
- i_sync without i_bit_valid is ignored.
- Frame completion:
  - o_data = captured bits [6:4].
  - o_crc_err = (final r != 0).
  - o_err_cnt increments on error unless it is already 255.
- Reset values: all outputs 0, state IDLE, r = 0, count = 0.
- Reset asserted mid-frame discards the partial frame with no pulse.

## Timing
- o_data_valid rises on the clock edge after the 7th accepted bit's edge, i.e. the registered outputs are visible one cycle after the 7th bit is sampled. It lasts exactly one cycle.
- o_data, o_crc_err and o_err_cnt update on the same edge as o_data_valid.
- Back-to-back frames: the sync bit of the next frame may arrive on the cycle immediately after the 7th bit. This gives full throughput of one codeword per 7 valid cycles.
- o_frame_abort is registered and asserts one cycle after the offending sync bit is sampled.
- Abort and completion never coincide: the 7th bit returns the FSM to IDLE, so an i_sync on that bit is treated as an abort.
- No combinational path exists from any input to any output.

## Structure
- Shared package crc_pkg holds:
  - GPE
  - CW_LEN
  - DATA_W = 3, CRC_W = 4
  - FSM state enum (IDLE, RECV)
- One sub-module, crc_serial_div: a 4-bit remainder register with load-first-bit, step and hold controls. It implements the update equation and exposes r.
- Top level holds the FSM, bit counter, capture shift register, error counter and output registers.

## Test plan
- Good frame: data 3'b101, CRC 4'b1100, bits 1,0,1,1,1,0,0 with sync on the first bit -> o_data_valid pulse with o_data = 3'b101, o_crc_err = 0, o_err_cnt = 0.
- Single-bit error: bits 1,0,0,1,1,0,0 -> o_data = 3'b100, o_crc_err = 1 (final r = 4'b0111), o_err_cnt = 1.
- Back-to-back with gaps: frame 011 1001, sync bit on the very next cycle for frame 101 1100, random i_bit_valid gaps inserted -> two pulses, both o_crc_err = 0, data 3'b011 then 3'b101.
- Abort: 4 bits of a frame, then i_sync with a new good frame -> o_frame_abort pulse, then exactly one o_data_valid for the new frame, o_crc_err = 0.
- Reset mid-frame after 3 bits, then a good frame -> no pulse from the partial frame, one correct pulse afterwards, all outputs 0 during reset.
- Saturation: 260 corrupted frames -> o_err_cnt stops at 255, and o_crc_err = 1 on every pulse.
